// File: rtl/hamming_encoder_tx_pkg.sv
// Shared constants for the Hamming(12,8) serial transmitter.
// State encoding and codeword bit placement.
package hamming_encoder_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam int DW   = 8;
  localparam int CW_W = 12;

  // Parity bits sit at the power-of-two positions (1-based 1,2,4,8)
  localparam logic [3:0] P0_POS = 4'd0;
  localparam logic [3:0] P1_POS = 4'd1;
  localparam logic [3:0] P2_POS = 4'd3;
  localparam logic [3:0] P3_POS = 4'd7;

  // Data bit i of the byte lands at codeword index D_POS[i]
  localparam logic [3:0] D_POS [DW] = '{
    4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11
  };

endpackage

// File: rtl/hamming_encoder_tx_if.sv
// Byte-in / serial-out bundle of the Hamming transmitter.
// slave = transmitter side, master = byte source / line observer.
interface hamming_encoder_tx_if;
  import hamming_encoder_tx_pkg::*;

  logic [DW-1:0]   din;
  logic            din_valid;
  logic            din_ready;
  logic            inj_en;
  logic [3:0]      inj_pos;
  logic [CW_W-1:0] cw_out;
  logic            tx_bit;
  logic            tx_busy;
  logic            frame_done;

  modport slave (
    input  din, din_valid, inj_en, inj_pos,
    output din_ready, cw_out, tx_bit, tx_busy, frame_done
  );

  modport master (
    output din, din_valid, inj_en, inj_pos,
    input  din_ready, cw_out, tx_bit, tx_busy, frame_done
  );

endinterface

// File: rtl/hamming_encoder_tx_encoder.sv
// Combinational Hamming(12,8) encoder with optional
// single-bit error injection for receiver testing.
module hamming_encoder
  import hamming_encoder_tx_pkg::*;
(
  input  logic [DW-1:0]   din,
  input  logic            inj_en,
  input  logic [3:0]      inj_pos,
  output logic [CW_W-1:0] cw
);

  logic [CW_W-1:0] w_raw;
  logic [CW_W-1:0] w_flip;

  // Place data bits, then derive the four parity bits
  always_comb begin
    w_raw = '0;
    for (int i = 0; i < DW; i++) begin
      w_raw[D_POS[i]] = din[i];
    end
    w_raw[P0_POS] = din[6] ^ din[4] ^ din[3]
                  ^ din[1] ^ din[0];
    w_raw[P1_POS] = din[6] ^ din[5] ^ din[3]
                  ^ din[2] ^ din[0];
    w_raw[P2_POS] = din[7] ^ din[3] ^ din[2]
                  ^ din[1];
    w_raw[P3_POS] = din[7] ^ din[6] ^ din[5]
                  ^ din[4];
  end

  // Injection mask; positions past the codeword mean no flip
  always_comb begin
    w_flip = '0;
    if (inj_en && (inj_pos < 4'(CW_W))) begin
      w_flip[inj_pos] = 1'b1;
    end
  end

  assign cw = w_raw ^ w_flip;

endmodule

// File: rtl/hamming_encoder_tx.sv
// Hamming(12,8) transmitter: accepts a byte, encodes it and
// sends start bit, 12 codeword bits MSB first, then stop bits.
module hamming_encoder_tx
  import hamming_encoder_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 2
) (
  input logic           clk,
  input logic           rst,
  hamming_encoder_tx_if.slave bus
);

  localparam logic [15:0] CNT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] CNT_PRE   = 16'(CLKS_PER_BIT - 2);
  localparam logic [3:0]  DATA_LAST = 4'(CW_W - 1);
  localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

  state_t          r_state;
  logic [15:0]     r_cnt;
  logic [3:0]      r_idx;
  logic [CW_W-1:0] r_cw;
  logic            r_tx_bit;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;

  logic [CW_W-1:0] w_cw;
  logic            w_accept;
  logic            w_bit_end;

  hamming_encoder u_enc (
    .din     (bus.din),
    .inj_en  (bus.inj_en),
    .inj_pos (bus.inj_pos),
    .cw      (w_cw)
  );

  // Ready is only ever high in IDLE, so this is the capture strobe
  assign w_accept  = r_ready & bus.din_valid;
  assign w_bit_end = (r_cnt == CNT_LAST);

  // Frame FSM, bit timer and serializer with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_cw     <= '0;
      r_tx_bit <= 1'b1;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_tx_bit <= 1'b1;
          r_cnt    <= '0;
          r_idx    <= '0;
          if (w_accept) begin
            r_state  <= ST_START;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_tx_bit <= 1'b0;
            r_cw     <= w_cw;
          end else begin
            r_ready <= 1'b1;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_state  <= ST_DATA;
            r_tx_bit <= r_cw[DATA_LAST];
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == DATA_LAST) begin
              r_state  <= ST_STOP;
              r_idx    <= '0;
              r_tx_bit <= 1'b1;
            end else begin
              r_idx    <= r_idx + 4'd1;
              r_tx_bit <= r_cw[DATA_LAST - r_idx - 4'd1];
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          // Pulse lands on the final cycle of the last stop bit
          if ((r_idx == STOP_LAST) && (r_cnt == CNT_PRE)) begin
            r_done <= 1'b1;
          end
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == STOP_LAST) begin
              r_state <= ST_IDLE;
              r_idx   <= '0;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.din_ready  = r_ready;
  assign bus.cw_out     = r_cw;
  assign bus.tx_bit     = r_tx_bit;
  assign bus.tx_busy    = r_busy;
  assign bus.frame_done = r_done;

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// Self-checking bench for hamming_encoder_tx.
// Reference: classic 1-based Hamming placement and a bit-list frame model.
module tb_hamming_encoder_tx;

  localparam int C  = 4;
  localparam int S  = 2;
  localparam int NB = (13 + S) * C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  hamming_encoder_tx_if bus();

  hamming_encoder_tx #(
    .CLKS_PER_BIT (C),
    .STOP_BITS    (S)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 1-based Hamming: data on non-power-of-two positions,
  // parity at 2^k covers every position with bit k set.
  function automatic logic [11:0] ref_cw(input logic [7:0] d,
                                          input bit e,
                                          input int p);
    logic [12:1] w;
    logic [11:0] r;
    logic        par;
    int          di;
    w  = '0;
    di = 0;
    for (int q = 1; q <= 12; q++) begin
      if ((q & (q - 1)) != 0) begin
        w[q] = d[di];
        di++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      par = 1'b0;
      for (int q = 1; q <= 12; q++) begin
        if (((q >> k) & 1) == 1 && q != (1 << k)) par ^= w[q];
      end
      w[1 << k] = par;
    end
    r = w;
    if (e && p < 12) r[p] = ~r[p];
    return r;
  endfunction

  function automatic int syndrome(input logic [11:0] cw);
    int s = 0;
    for (int q = 1; q <= 12; q++) if (cw[q-1]) s ^= q;
    return s;
  endfunction

  function automatic logic [7:0] decode(input logic [11:0] cw);
    logic [11:0] c;
    logic [7:0]  d;
    int          s;
    int          di;
    c = cw;
    s = syndrome(cw);
    if (s >= 1 && s <= 12) c[s-1] = ~c[s-1];
    di = 0;
    d  = '0;
    for (int q = 1; q <= 12; q++) begin
      if ((q & (q - 1)) != 0) begin
        d[di] = c[q-1];
        di++;
      end
    end
    return d;
  endfunction

  // Present a byte and wait (bounded) for its acceptance edge
  task automatic offer(input logic [7:0] d, input bit e,
                       input logic [3:0] p);
    int w = 0;
    bus.din       = d;
    bus.inj_en    = e;
    bus.inj_pos   = p;
    bus.din_valid = 1'b1;
    while (bus.din_ready !== 1'b1 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk("ready_wait_ok", 32'(w < 200), 32'd1);
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
  endtask

  // Follow one frame from its first START cycle.
  // mode 1: hold a next byte valid while busy; mode 2: pulse one.
  task automatic run_frame(input logic [11:0] ecw, input int mode,
                           input logic [7:0] nd);
    int   bi;
    logic eb;
    chk("cw_out_start", 32'(bus.cw_out), 32'(ecw));
    chk("busy_start", 32'(bus.tx_busy), 32'd1);
    chk("ready_start", 32'(bus.din_ready), 32'd0);
    for (int k = 0; k < NB; k++) begin
      bi = k / C;
      if (bi == 0)       eb = 1'b0;
      else if (bi <= 12) eb = ecw[12 - bi];
      else               eb = 1'b1;
      if (mode != 0 && k == 7) begin
        bus.din       = nd;
        bus.inj_en    = 1'b0;
        bus.din_valid = 1'b1;
      end
      if (mode == 2 && k == 8) bus.din_valid = 1'b0;
      chk("tx_bit", 32'(bus.tx_bit), 32'(eb));
      chk("frame_done", 32'(bus.frame_done), 32'(k == NB - 1));
      chk("tx_busy", 32'(bus.tx_busy), 32'd1);
      @(posedge clk); #1;
    end
    chk("ready_after", 32'(bus.din_ready), 32'd1);
    chk("busy_after", 32'(bus.tx_busy), 32'd0);
    chk("done_after", 32'(bus.frame_done), 32'd0);
    chk("cw_out_held", 32'(bus.cw_out), 32'(ecw));
    if (mode == 1) begin
      @(posedge clk); #1;
      bus.din_valid = 1'b0;
    end
    if (mode == 2) begin
      @(posedge clk); #1;
      chk("no_capture_busy", 32'(bus.tx_busy), 32'd0);
      chk("no_capture_cw", 32'(bus.cw_out), 32'(ecw));
    end
  endtask

  initial begin
    logic [7:0] d;
    bit         e;
    logic [3:0] p;
    logic [11:0] ecw;

    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.inj_en    = 1'b0;
    bus.inj_pos   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_bit", 32'(bus.tx_bit), 32'd1);
    chk("rst_ready", 32'(bus.din_ready), 32'd0);
    chk("rst_busy", 32'(bus.tx_busy), 32'd0);
    chk("rst_done", 32'(bus.frame_done), 32'd0);
    chk("rst_cw", 32'(bus.cw_out), 32'd0);

    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(bus.din_ready), 32'd1);

    offer(8'h00, 1'b0, 4'd0);
    chk("cw_00", 32'(bus.cw_out), 32'h000);
    run_frame(ref_cw(8'h00, 1'b0, 0), 0, 8'h00);

    offer(8'hFF, 1'b0, 4'd0);
    chk("cw_FF", 32'(bus.cw_out), 32'hF77);
    run_frame(ref_cw(8'hFF, 1'b0, 0), 0, 8'h00);

    offer(8'hA5, 1'b0, 4'd0);
    chk("cw_A5", 32'(bus.cw_out), 32'hA27);
    run_frame(ref_cw(8'hA5, 1'b0, 0), 0, 8'h00);

    offer(8'hA5, 1'b1, 4'd2);
    chk("cw_A5_inj2", 32'(bus.cw_out), 32'hA23);
    chk("syndrome_A23", 32'(syndrome(bus.cw_out)), 32'd3);
    chk("decode_A23", 32'(decode(bus.cw_out)), 32'hA5);
    run_frame(ref_cw(8'hA5, 1'b1, 2), 0, 8'h00);

    offer(8'h5A, 1'b1, 4'd14);
    run_frame(ref_cw(8'h5A, 1'b0, 0), 0, 8'h00);

    // Back-to-back: next byte held valid during busy
    offer(8'h3C, 1'b0, 4'd0);
    run_frame(ref_cw(8'h3C, 1'b0, 0), 1, 8'hC3);
    run_frame(ref_cw(8'hC3, 1'b0, 0), 2, 8'h55);

    // Reset during DATA bit 5
    offer(8'h96, 1'b1, 4'd13);
    repeat (6 * C) @(posedge clk);
    #1;
    ecw = ref_cw(8'h96, 1'b0, 0);
    chk("pre_rst_bit5", 32'(bus.tx_bit), 32'(ecw[6]));
    rst = 1'b1;
    #1;
    chk("async_tx_bit", 32'(bus.tx_bit), 32'd1);
    chk("async_busy", 32'(bus.tx_busy), 32'd0);
    chk("async_ready", 32'(bus.din_ready), 32'd0);
    chk("async_cw", 32'(bus.cw_out), 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_abort", 32'(bus.din_ready), 32'd1);
    chk("idle_after_abort", 32'(bus.tx_bit), 32'd1);
    offer(8'h69, 1'b0, 4'd0);
    run_frame(ref_cw(8'h69, 1'b0, 0), 0, 8'h00);

    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      e = 1'($urandom_range(0, 1));
      p = 4'($urandom_range(0, 15));
      offer(d, e, p);
      run_frame(ref_cw(d, e, int'(p)), 0, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
